// File: rtl/network_stream_adapter.sv
// network_stream_adapter: valid/ready front/back end for the network core.
// An input FIFO feeds one sample at a time onto net_inp. The register advances
// only on a rising edge of net_out_v, which marks a completed network pass.
// Each result is captured into an output FIFO that drains to a valid/ready sink.
// Optional build macro NETWORK_STREAM_ADAPTER_STATS_EN adds saturating
// sample/underrun/overflow counters.
module network_stream_adapter #(
    parameter int W         = 16,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [W-1:0] net_inp,
    input  logic [W-1:0] net_out_d0,
    input  logic [W-1:0] net_out_d1,
    input  logic [W-1:0] net_out_d2,
    input  logic [W-1:0] net_out_d3,
    input  logic         net_out_v,
    output logic [W-1:0] m_d0,
    output logic [W-1:0] m_d1,
    output logic [W-1:0] m_d2,
    output logic [W-1:0] m_d3,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         underrun,
`ifdef NETWORK_STREAM_ADAPTER_STATS_EN
    output logic [15:0]  stat_samples,
    output logic [15:0]  stat_underruns,
    output logic [15:0]  stat_overflows,
`endif
    output logic         overflow
);
    // state | meaning
    // PRIME | first pass after reset runs on zero input; its result is discarded
    // RUN   | every pass result is captured into the output FIFO
    typedef enum logic {PRIME = 1'b0, RUN = 1'b1} state_t;

    localparam int IAW = $clog2(IN_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);
    localparam logic [IAW:0] I_ONE = (IAW + 1)'(1);
    localparam logic [OAW:0] O_ONE = (OAW + 1)'(1);

    state_t         r_state, w_state_nxt;
    logic           r_out_v_q;
    logic           w_ev, w_capture;

    logic [W-1:0]   r_in_mem [IN_DEPTH];
    logic [IAW:0]   r_in_wp, r_in_rp;
    logic           w_in_full, w_in_empty, w_in_push, w_in_pop;

    logic [4*W-1:0] r_out_mem [OUT_DEPTH];
    logic [OAW:0]   r_out_wp, r_out_rp;
    logic           w_out_full, w_out_empty, w_out_push, w_out_pop;
    logic [4*W-1:0] w_out_head;

    assign w_ev       = net_out_v && !r_out_v_q;

    assign w_in_empty = (r_in_wp == r_in_rp);
    assign w_in_full  = (r_in_wp[IAW] != r_in_rp[IAW]) &&
                        (r_in_wp[IAW-1:0] == r_in_rp[IAW-1:0]);
    assign s_ready    = !w_in_full;
    assign w_in_push  = s_valid && !w_in_full;
    assign w_in_pop   = w_ev && !w_in_empty;

    assign w_out_empty = (r_out_wp == r_out_rp);
    assign w_out_full  = (r_out_wp[OAW] != r_out_rp[OAW]) &&
                         (r_out_wp[OAW-1:0] == r_out_rp[OAW-1:0]);
    assign m_valid     = !w_out_empty;
    assign w_out_pop   = m_valid && m_ready;
    // A full FIFO still accepts a result when the sink frees a slot this cycle.
    assign w_out_push  = w_capture && (!w_out_full || w_out_pop);
    assign w_out_head  = r_out_mem[r_out_rp[OAW-1:0]];
    assign {m_d0, m_d1, m_d2, m_d3} = w_out_head;

    // State register and net_out_v edge detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= PRIME;
            r_out_v_q <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_out_v_q <= net_out_v;
        end
    end

    // Next-state logic; capture only happens for passes after priming.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            PRIME:   if (w_ev) w_state_nxt = RUN;
            RUN:     w_capture = w_ev;
            default: w_state_nxt = PRIME;
        endcase
    end

    // Input FIFO storage; contents need no reset since pointers gate reads.
    always_ff @(posedge clk) begin
        if (w_in_push) r_in_mem[r_in_wp[IAW-1:0]] <= s_data;
    end

    // Input FIFO pointers, net_inp advance and underrun pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_wp  <= '0;
            r_in_rp  <= '0;
            net_inp  <= '0;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (w_in_push) r_in_wp <= r_in_wp + I_ONE;
            if (w_ev) begin
                if (w_in_empty) begin
                    net_inp  <= '0;
                    underrun <= 1'b1;
                end else begin
                    net_inp <= r_in_mem[r_in_rp[IAW-1:0]];
                    r_in_rp <= r_in_rp + I_ONE;
                end
            end
        end
    end

    // Output FIFO; storage is reset so m_d* read zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_wp <= '0;
            r_out_rp <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < OUT_DEPTH; i++) r_out_mem[i] <= '0;
        end else begin
            overflow <= w_capture && w_out_full && !w_out_pop;
            if (w_out_push) begin
                r_out_mem[r_out_wp[OAW-1:0]] <= {net_out_d0, net_out_d1, net_out_d2, net_out_d3};
                r_out_wp <= r_out_wp + O_ONE;
            end
            if (w_out_pop) r_out_rp <= r_out_rp + O_ONE;
        end
    end

`ifdef NETWORK_STREAM_ADAPTER_STATS_EN
    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_samples   <= '0;
            stat_underruns <= '0;
            stat_overflows <= '0;
        end else begin
            if (w_capture && stat_samples != 16'hFFFF) stat_samples <= stat_samples + 16'd1;
            if (underrun && stat_underruns != 16'hFFFF) stat_underruns <= stat_underruns + 16'd1;
            if (overflow && stat_overflows != 16'hFFFF) stat_overflows <= stat_overflows + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_network_stream_adapter.sv
// Directed bench for network_stream_adapter. Expected results are queued when
// a pass is issued; a negedge monitor pops and compares on each sink handshake.
module tb_network_stream_adapter;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] s_data = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [W-1:0] net_inp;
    logic [W-1:0] net_out_d0 = '0, net_out_d1 = '0, net_out_d2 = '0, net_out_d3 = '0;
    logic         net_out_v = 1'b0;
    logic [W-1:0] m_d0, m_d1, m_d2, m_d3;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic         underrun, overflow;
`ifdef NETWORK_STREAM_ADAPTER_STATS_EN
    logic [15:0]  stat_samples, stat_underruns, stat_overflows;
`endif

    int n_vec = 0;
    int n_err = 0;
    int n_und = 0;
    int n_ovf = 0;
    logic [4*W-1:0] exp_q[$];

    always #5 clk = ~clk;

    network_stream_adapter #(.W(W), .IN_DEPTH(4), .OUT_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .net_inp(net_inp),
        .net_out_d0(net_out_d0), .net_out_d1(net_out_d1),
        .net_out_d2(net_out_d2), .net_out_d3(net_out_d3),
        .net_out_v(net_out_v),
        .m_d0(m_d0), .m_d1(m_d1), .m_d2(m_d2), .m_d3(m_d3),
        .m_valid(m_valid), .m_ready(m_ready),
        .underrun(underrun),
`ifdef NETWORK_STREAM_ADAPTER_STATS_EN
        .stat_samples(stat_samples), .stat_underruns(stat_underruns),
        .stat_overflows(stat_overflows),
`endif
        .overflow(overflow)
    );

    function automatic logic [4*W-1:0] res(input int k);
        return {W'(k), W'(k + 1), W'(k + 2), W'(k + 3)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare every sink handshake against the queue head.
    initial begin
        logic [4*W-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (underrun) n_und++;
                if (overflow) n_ovf++;
                if (m_valid && m_ready) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_result: got %h expected none", {m_d0, m_d1, m_d2, m_d3});
                    end else begin
                        e = exp_q.pop_front();
                        if ({m_d0, m_d1, m_d2, m_d3} !== e) begin
                            n_err++;
                            $display("FAIL result: got %h expected %h", {m_d0, m_d1, m_d2, m_d3}, e);
                        end
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    // One network pass: result k..k+3, out_v held high for 'hold' edges.
    task automatic do_ev(input int k, input int hold, input bit exp_push, input bit rdy_pulse);
        @(posedge clk); #1;
        net_out_v = 1'b1;
        {net_out_d0, net_out_d1, net_out_d2, net_out_d3} = res(k);
        if (rdy_pulse) m_ready = 1'b1;
        if (exp_push) exp_q.push_back(res(k));
        repeat (hold) @(posedge clk);
        #1;
        net_out_v = 1'b0;
        if (rdy_pulse) m_ready = 1'b0;
    endtask

    task automatic push_s(input logic [W-1:0] d);
        @(posedge clk); #1;
        s_valid = 1'b1;
        s_data  = d;
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 60) begin
            @(posedge clk);
            t++;
        end
        #1;
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int u0, o0, pushed;
        logic r;
        logic [W-1:0] exp_inp [5];

        // Reset values
        idle(2);
        rst = 1'b0;
        idle(1);
        check("rst_net_inp", 64'(net_inp), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd1);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_d", {m_d0, m_d1, m_d2, m_d3}, 64'd0);
        check("rst_pulses", {62'd0, underrun, overflow}, 64'd0);

        // 3 passes with no input; second pass holds out_v for 3 edges
        m_ready = 1'b1;
        u0 = n_und;
        do_ev(1, 1, 1'b0, 1'b0); idle(3);
        do_ev(2, 3, 1'b1, 1'b0); idle(3);
        do_ev(3, 1, 1'b1, 1'b0); idle(3);
        check("t1_net_inp", 64'(net_inp), 64'd0);
        check("t1_underruns", 64'(n_und - u0), 64'd3);
        wait_drain("t1_drain");
`ifdef NETWORK_STREAM_ADAPTER_STATS_EN
        check("t1_stat_samples", 64'(stat_samples), 64'd2);
        check("t1_stat_underruns", 64'(stat_underruns), 64'd3);
`endif

        // Buffered samples then 4 passes
        do_reset();
        m_ready = 1'b1;
        u0 = n_und;
        push_s(16'h0100); push_s(16'h0200); push_s(16'h0300);
        exp_inp[0] = 16'h0100; exp_inp[1] = 16'h0200; exp_inp[2] = 16'h0300; exp_inp[3] = 16'h0000;
        for (int k = 1; k <= 4; k++) begin
            do_ev(k, 1, k > 1, 1'b0);
            check($sformatf("t2_net_inp_%0d", k), 64'(net_inp), 64'(exp_inp[k-1]));
            idle(2);
        end
        check("t2_underruns", 64'(n_und - u0), 64'd1);
        wait_drain("t2_drain");

        // Output FIFO overflow with sink stalled
        do_reset();
        m_ready = 1'b0;
        o0 = n_ovf;
        do_ev(1, 1, 1'b0, 1'b0); idle(1);
        for (int k = 10; k < 16; k++) begin
            do_ev(k, 1, k < 14, 1'b0);
            idle(1);
        end
        check("t3_overflows", 64'(n_ovf - o0), 64'd2);
        check("t3_m_valid", 64'(m_valid), 64'd1);
        check("t3_head_stable", {m_d0, m_d1, m_d2, m_d3}, res(10));
        m_ready = 1'b1;
        wait_drain("t3_drain");
        idle(2);
        check("t3_empty", 64'(m_valid), 64'd0);

        // Full output FIFO with pop in the same cycle as the pass
        do_reset();
        m_ready = 1'b0;
        o0 = n_ovf;
        do_ev(1, 1, 1'b0, 1'b0); idle(1);
        for (int k = 20; k < 24; k++) begin
            do_ev(k, 1, 1'b1, 1'b0);
            idle(1);
        end
        do_ev(24, 1, 1'b1, 1'b1); idle(1);
        check("t5_no_overflow", 64'(n_ovf - o0), 64'd0);
        do_ev(25, 1, 1'b0, 1'b0); idle(1);
        check("t5_still_full", 64'(n_ovf - o0), 64'd1);
        m_ready = 1'b1;
        wait_drain("t5_drain");

        // Input FIFO backpressure: 5 samples, s_valid held high
        do_reset();
        m_ready = 1'b1;
        u0 = n_und;
        pushed = 0;
        @(posedge clk); #1;
        s_valid = 1'b1;
        s_data  = 16'h00A1;
        repeat (8) begin
            @(negedge clk);
            r = s_ready;
            @(posedge clk); #1;
            if (r) begin
                pushed++;
                s_data = 16'h00A1 + W'(pushed);
            end
        end
        check("t4_pushed", 64'(pushed), 64'd4);
        check("t4_s_ready_full", 64'(s_ready), 64'd0);
        do_ev(1, 1, 1'b0, 1'b0);
        check("t4_net_inp_0", 64'(net_inp), 64'h00A1);
        @(negedge clk);
        check("t4_s_ready_freed", 64'(s_ready), 64'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        exp_inp[0] = 16'h00A2; exp_inp[1] = 16'h00A3; exp_inp[2] = 16'h00A4;
        exp_inp[3] = 16'h00A5; exp_inp[4] = 16'h0000;
        for (int k = 0; k < 5; k++) begin
            do_ev(30 + k, 1, 1'b1, 1'b0);
            check($sformatf("t4_net_inp_%0d", k + 1), 64'(net_inp), 64'(exp_inp[k]));
            idle(1);
        end
        check("t4_underruns", 64'(n_und - u0), 64'd1);
        wait_drain("t4_drain");

        // Reset mid-stream with 2 entries in each FIFO
        do_reset();
        m_ready = 1'b0;
        do_ev(1, 1, 1'b0, 1'b0); idle(1);
        do_ev(40, 1, 1'b0, 1'b0); idle(1);
        do_ev(41, 1, 1'b0, 1'b0); idle(1);
        push_s(16'h0055); push_s(16'h0066);
        check("t6_pre_m_valid", 64'(m_valid), 64'd1);
        check("t6_pre_s_ready", 64'(s_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("t6_rst_m_valid", 64'(m_valid), 64'd0);
        check("t6_rst_m_d", {m_d0, m_d1, m_d2, m_d3}, 64'd0);
        check("t6_rst_net_inp", 64'(net_inp), 64'd0);
`ifdef NETWORK_STREAM_ADAPTER_STATS_EN
        check("t6_rst_stats", {16'd0, stat_samples, stat_underruns, stat_overflows}, 64'd0);
`endif
        idle(1);
        rst = 1'b0;
        m_ready = 1'b1;
        u0 = n_und;
        do_ev(50, 1, 1'b0, 1'b0); idle(3);
        check("t6_prime_discard", 64'(m_valid), 64'd0);
        check("t6_prime_underrun", 64'(n_und - u0), 64'd1);
        do_ev(51, 1, 1'b1, 1'b0);
        wait_drain("t6_drain");

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
